// File: rtl/rgb_gray_packer_if.sv
// -----------------------------------------------------------------------------
// rgb_gray_packer_if
//   Bundles the byte-stream input and the tagged-pixel output of
//   rgb_gray_packer.
//
//   Byte side  : in_valid, in_data[7:0]      (driven by the image source)
//   Pixel side : out_valid, out_gray[7:0], out_x[XW-1:0], out_y[YW-1:0],
//                out_sof, out_eol, out_eof, frame_cnt[15:0]
//
//   modport master : the environment (drives bytes, observes pixels)
//   modport slave  : the packer itself (consumes bytes, produces pixels)
// -----------------------------------------------------------------------------
interface rgb_gray_packer_if #(
   parameter int XW = 9,
   parameter int YW = 9
);
   logic          in_valid;
   logic [7:0]    in_data;
   logic          out_valid;
   logic [7:0]    out_gray;
   logic [XW-1:0] out_x;
   logic [YW-1:0] out_y;
   logic          out_sof;
   logic          out_eol;
   logic          out_eof;
   logic [15:0]   frame_cnt;

   modport master (
      output in_valid, in_data,
      input  out_valid, out_gray, out_x, out_y,
      input  out_sof, out_eol, out_eof, frame_cnt
   );

   modport slave (
      input  in_valid, in_data,
      output out_valid, out_gray, out_x, out_y,
      output out_sof, out_eol, out_eof, frame_cnt
   );
endinterface

// File: rtl/rgb_gray_packer.sv
// -----------------------------------------------------------------------------
// rgb_gray_packer
//   Packs an interleaved R,G,B byte stream into pixels, converts each pixel to
//   8-bit luma (77R + 150G + 29B) >> 8 and tags it with x/y coordinates and
//   start-of-frame / end-of-line / end-of-frame markers.
//
//   Ports:
//     clk  : system clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : rgb_gray_packer_if.slave
//            in_valid/in_data          byte strobe and byte from the source
//            out_valid                 one-cycle strobe per completed pixel
//            out_gray                  luma of the pixel (holds when idle)
//            out_x/out_y               pixel coordinates (hold when idle)
//            out_sof/out_eol/out_eof   markers, qualified by out_valid
//            frame_cnt                 completed frames, wraps at 16 bits
//
//   A cycle with in_valid low resynchronises: byte phase and coordinates go
//   back to pixel (0,0) because the source restarts its frame whenever its
//   enable drops. Partial pixels are dropped silently.
// -----------------------------------------------------------------------------
module rgb_gray_packer #(
   parameter int N  = 450,
   parameter int M  = 450,
   parameter int XW = 9,
   parameter int YW = 9
) (
   input  logic               clk,
   input  logic               rst,
   rgb_gray_packer_if.slave   bus
);

   typedef enum logic [1:0] {
      PH_R = 2'd0,
      PH_G = 2'd1,
      PH_B = 2'd2
   } ph_t;

   localparam logic [XW-1:0] X_LAST = XW'(N - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(M - 1);

   // Luma in 16 bits; max is 255*256 = 65280, so no overflow. Truncating.
   function automatic logic [7:0] luma_f(input logic [7:0] r,
                                         input logic [7:0] g,
                                         input logic [7:0] b);
      logic [15:0] sum_v;
      sum_v = (16'd77  * {8'd0, r}) +
              (16'd150 * {8'd0, g}) +
              (16'd29  * {8'd0, b});
      return sum_v[15:8];
   endfunction

   ph_t           ph_r;
   ph_t           ph_nxt_s;
   logic          pix_done_s;
   logic          last_col_s;
   logic          last_row_s;
   logic          first_pix_s;

   logic [7:0]    r_r;
   logic [7:0]    g_r;
   logic [XW-1:0] x_r;
   logic [YW-1:0] y_r;

   logic          out_valid_r;
   logic [7:0]    out_gray_r;
   logic [XW-1:0] out_x_r;
   logic [YW-1:0] out_y_r;
   logic          out_sof_r;
   logic          out_eol_r;
   logic          out_eof_r;
   logic [15:0]   frame_cnt_r;

   // Byte-phase state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         ph_r <= PH_R;
      end else begin
         ph_r <= ph_nxt_s;
      end
   end

   // Byte-phase next state: advance on accepted bytes, resync on idle cycles.
   always_comb begin
      ph_nxt_s = PH_R;
      if (!bus.in_valid) begin
         ph_nxt_s = PH_R;
      end else begin
         case (ph_r)
            PH_R:    ph_nxt_s = PH_G;
            PH_G:    ph_nxt_s = PH_B;
            PH_B:    ph_nxt_s = PH_R;
            default: ph_nxt_s = PH_R;
         endcase
      end
   end

   // Phase decode: pixel completion and position flags of the pixel in work.
   always_comb begin
      pix_done_s  = 1'b0;
      last_col_s  = (x_r == X_LAST);
      last_row_s  = (y_r == Y_LAST);
      first_pix_s = (x_r == {XW{1'b0}}) && (y_r == {YW{1'b0}});
      if (bus.in_valid && (ph_r == PH_B)) begin
         pix_done_s = 1'b1;
      end else begin
         pix_done_s = 1'b0;
      end
   end

   // R/G holding registers, loaded on their byte phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_r <= 8'd0;
         g_r <= 8'd0;
      end else begin
         if (bus.in_valid && (ph_r == PH_R)) begin
            r_r <= bus.in_data;
         end
         if (bus.in_valid && (ph_r == PH_G)) begin
            g_r <= bus.in_data;
         end
      end
   end

   // Coordinate counters of the pixel being assembled.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_r <= {XW{1'b0}};
         y_r <= {YW{1'b0}};
      end else if (!bus.in_valid) begin
         x_r <= {XW{1'b0}};
         y_r <= {YW{1'b0}};
      end else if (pix_done_s) begin
         if (last_col_s) begin
            x_r <= {XW{1'b0}};
            y_r <= last_row_s ? {YW{1'b0}} : (y_r + YW'(1));
         end else begin
            x_r <= x_r + XW'(1);
         end
      end
   end

   // Registered pixel outputs; markers are cleared whenever no pixel is out.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_gray_r  <= 8'd0;
         out_x_r     <= {XW{1'b0}};
         out_y_r     <= {YW{1'b0}};
         out_sof_r   <= 1'b0;
         out_eol_r   <= 1'b0;
         out_eof_r   <= 1'b0;
         frame_cnt_r <= 16'd0;
      end else begin
         out_valid_r <= pix_done_s;
         if (pix_done_s) begin
            out_gray_r <= luma_f(r_r, g_r, bus.in_data);
            out_x_r    <= x_r;
            out_y_r    <= y_r;
            out_sof_r  <= first_pix_s;
            out_eol_r  <= last_col_s;
            out_eof_r  <= last_col_s && last_row_s;
            if (last_col_s && last_row_s) begin
               frame_cnt_r <= frame_cnt_r + 16'd1;
            end
         end else begin
            out_sof_r <= 1'b0;
            out_eol_r <= 1'b0;
            out_eof_r <= 1'b0;
         end
      end
   end

   assign bus.out_valid = out_valid_r;
   assign bus.out_gray  = out_gray_r;
   assign bus.out_x     = out_x_r;
   assign bus.out_y     = out_y_r;
   assign bus.out_sof   = out_sof_r;
   assign bus.out_eol   = out_eol_r;
   assign bus.out_eof   = out_eof_r;
   assign bus.frame_cnt = frame_cnt_r;

endmodule

// File: doc/rgb_gray_packer.md
Name: rgb_gray_packer

Overview:
- Sits directly downstream of the camera/image byte source.
- Consumes the source's interleaved byte stream: R, G, B per pixel, row-major, N×M pixels per frame.
- Packs each byte triple into one pixel, converts it to 8-bit luma, and tags it with x/y coordinates and frame/line markers.
- Output feeds the grayscale processing stages.

Parameters:
- N, 450, frame width in pixels
- M, 450, frame height in lines
- XW, 9, width of x coordinate (must satisfy 2^XW >= N)
- YW, 9, width of y coordinate (must satisfy 2^YW >= M)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  byte strobe from source (source data_valid)
- in_data  in  8  byte from source (source data_out); don't-care/Z when in_valid=0
- out_valid  out  1  one-cycle strobe per completed pixel
- out_gray  out  8  luma of completed pixel
- out_x  out  XW  column of pixel, 0..N-1
- out_y  out  YW  row of pixel, 0..M-1
- out_sof  out  1  high with out_valid for pixel (0,0)
- out_eol  out  1  high with out_valid for pixel x=N-1
- out_eof  out  1  high with out_valid for pixel (N-1,M-1)
- frame_cnt  out  16  count of completed frames, wraps at 65535->0

Behaviour:
- Reset (rst=1 at a clk edge): clear to 0 byte phase, R/G holding regs, x/y counters, all outputs, frame_cnt.
- Byte phase counter ph cycles 0 (R), 1 (G), 2 (B); it advances only on cycles with in_valid=1.
  - ph=0: latch R. ph=1: latch G. ph=2: pixel completes, ph->0.
- Resync rule: any cycle with in_valid=0 forces ph=0 and x=y=0.
  - Reason: the source restarts its frame at byte 0 whenever its enable drops.
  - Partially received pixels are discarded. out_valid is not asserted for them.
  - frame_cnt is not changed by a resync.
- Luma: sum = 77*R + 150*G + 29*B, computed unsigned in 16 bits (max 65280, no overflow).
  - out_gray = sum[15:8], truncate, no rounding.
  - Check values: white (255,255,255)->255; black->0; (255,0,0)->76.
- Latency: out_valid and all tags are registered and assert on the clk edge after the cycle in which the B byte is accepted.
  - out_valid is high for exactly one cycle per pixel and low otherwise.
  - out_gray/x/y hold their last values while out_valid=0.
- Coordinates: out_x/out_y carry the coordinates of the completing pixel.
  - After each pixel, x increments. At x=N-1, x->0 and y increments. At (N-1,M-1), x->0, y->0.
  - On that eof pixel, frame_cnt increments on the same edge out_eof asserts.
- Markers are qualified by out_valid; they are 0 whenever out_valid=0.
  - For N=1, out_sof and out_eol may be high together.
  - out_eof implies out_eol.
- Back-to-back frames with continuous in_valid: no bubble. Pixel (0,0) of the next frame follows eof with normal 3-byte spacing.
- rst has priority over in_valid. Reset mid-pixel or mid-frame discards all state. The next accepted byte is treated as R of pixel (0,0).
- No backpressure: the block always accepts bytes; the downstream must accept one pixel per 3 clocks.

Test Plan:
- Reset then bytes FF,FF,FF continuous -> out_valid one cycle after third byte, out_gray=FF, x=0, y=0, out_sof=1; then 00,00,00 -> out_gray=00, x=1, sof=0.
- Bytes FF,00,00 then 00,FF,00 then 00,00,FF -> out_gray=4C, 95, 1C respectively; out_valid exactly every 3rd cycle.
- N=4, M=2, continuous 24 bytes -> eol at x=3 for y=0 and y=1; eof+eol on 8th pixel; frame_cnt 0->1; 9th pixel is (0,0) with sof.
- N=4, M=2: send 2 bytes, drop in_valid 1 cycle, resume -> no pixel from the partial bytes; next pixel formed from bytes 3..5 is (0,0) with sof; frame_cnt unchanged.
- Mid-frame at pixel (2,1) assert rst 1 cycle with in_valid=1 -> all outputs 0 the next cycle; subsequent pixel is (0,0), frame_cnt=0.
- Run 3 full frames N=4, M=2 continuous -> frame_cnt=3, exactly 3 eof pulses, 24 out_valid pulses, no gaps at frame boundaries.
